noc_length_to_last: RTL and testbench



---
 rtl/noc_length_to_last.sv | 116 +++++++++++
 tb/tb_noc_length_to_last.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_length_to_last.sv
// Purpose : unpack one length-tagged message (payload + byte count) into a stream of beats with last on the final beat.
// Latency : 1 cycle from enq to first beat; back-to-back messages flow through with no idle cycle.
// Backpr. : beat holds while deq__ENA=0; enq__RDY drops until the final beat of the held message is taken.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   enq__ENA/enq__RDY     message handshake; enq_v payload (byte 0 = bits [7:0]), enq_size length in bytes
//   deq__ENA/deq__RDY     beat handshake
//   first, first__RDY     current beat data and its valid (same as deq__RDY)
//   last, last__RDY       final-beat flag and its valid (same as deq__RDY)
module noc_length_to_last #(
    parameter int DATA_WIDTH = 128,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enq__ENA,
    input  logic [DATA_WIDTH-1:0] enq_v,
    input  logic [15:0]           enq_size,
    output logic                  enq__RDY,
    input  logic                  deq__ENA,
    output logic                  deq__RDY,
    output logic [BEAT_WIDTH-1:0] first,
    output logic                  first__RDY,
    output logic                  last,
    output logic                  last__RDY
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int BPB      = BEAT_WIDTH / 8;
    localparam int MAXBEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam int IDX_W    = (MAXBEATS > 1) ? $clog2(MAXBEATS) : 1;
    localparam int NB_W     = $clog2(MAXBEATS + 1);

    localparam logic [15:0] BYTES16 = 16'(BYTES);
    localparam logic [15:0] BPB16   = 16'(BPB);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [NB_W-1:0]       nbeats;
    logic [DATA_WIDTH-1:0] buffer;
    logic [15:0]           size_q;   // effective (clamped) byte count of the held message

    logic [15:0]           eff_size;
    logic [NB_W-1:0]       nbeats_in;
    logic                  in_send;
    logic                  is_final;
    logic                  enq_fire;
    logic                  deq_fire;
    logic [15:0]           beat_base;
    logic [BEAT_WIDTH-1:0] beat_dat;

    // Lengths beyond the payload width are clamped; beat count rounds up.
    assign eff_size  = (enq_size > BYTES16) ? BYTES16 : enq_size;
    assign nbeats_in = NB_W'((eff_size + (BPB16 - 16'd1)) / BPB16);

    assign in_send  = (state == ST_SEND);
    assign is_final = (NB_W'(idx) == (nbeats - 1'b1));

    assign deq__RDY   = in_send;
    assign first__RDY = in_send;
    assign last__RDY  = in_send;
    assign last       = in_send & is_final;

    // Flow-through: taking the final beat frees the buffer in the same cycle,
    // so the next message may load without an idle cycle. Deliberately
    // independent of enq__ENA.
    assign enq__RDY = ~in_send | (deq__ENA & last);

    assign enq_fire = enq__ENA & enq__RDY;
    assign deq_fire = deq__ENA & in_send;

    // Byte lanes past the message length only occur on the final beat; they
    // are zeroed so stale payload bits never leak out.
    always_comb begin
        beat_base = 16'(idx) * BPB16;
        beat_dat  = buffer[idx*BEAT_WIDTH +: BEAT_WIDTH];
        for (int b = 0; b < BPB; b++) begin
            if (is_final && ((beat_base + 16'(b)) >= size_q)) begin
                beat_dat[b*8 +: 8] = 8'h00;
            end
        end
        first = in_send ? beat_dat : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            idx    <= '0;
            nbeats <= '0;
            buffer <= '0;
            size_q <= '0;
        end else if (enq_fire && (eff_size != 16'd0)) begin
            // Also covers the flow-through case: the final beat leaves as the
            // new message lands, so state stays SEND with idx restarted.
            buffer <= enq_v;
            size_q <= eff_size;
            nbeats <= nbeats_in;
            idx    <= '0;
            state  <= ST_SEND;
        end else if (deq_fire) begin
            // A zero-length enq arriving with the final deq lands here and is
            // simply dropped.
            if (is_final) begin
                state <= ST_IDLE;
                idx   <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_length_to_last.sv
// Purpose : self-checking bench for noc_length_to_last (table of messages plus hand-written corner sequences).
// Latency : expected beats are queued when an enq is seen to fire and compared as the DUT emits them.
// Backpr. : bench drives deq__ENA itself to exercise stalls, flow-through and mid-message reset.
module tb_noc_length_to_last;

    localparam int DW = 128;
    localparam int BW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          enq__ENA;
    logic [DW-1:0] enq_v;
    logic [15:0]   enq_size;
    logic          enq__RDY;
    logic          deq__ENA;
    logic          deq__RDY;
    logic [BW-1:0] first;
    logic          first__RDY;
    logic          last;
    logic          last__RDY;

    always #5 CLK = ~CLK;

    noc_length_to_last #(.DATA_WIDTH(DW), .BEAT_WIDTH(BW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .enq__ENA   (enq__ENA),
        .enq_v      (enq_v),
        .enq_size   (enq_size),
        .enq__RDY   (enq__RDY),
        .deq__ENA   (deq__ENA),
        .deq__RDY   (deq__RDY),
        .first      (first),
        .first__RDY (first__RDY),
        .last       (last),
        .last__RDY  (last__RDY)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    typedef struct {
        logic [DW-1:0] v;
        logic [15:0]   size;
        int            n_beats;
        logic [31:0]   last_beat;
    } vec_t;

    localparam logic [DW-1:0] PAT = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    exp_t        sb[$];
    int          beat_cycles[$];
    int          beat_cnt;
    logic [31:0] last_data;
    logic [7:0]  last_hist;
    exp_t        mon_e;

    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte j of the message is payload byte j when j is
    // below the clamped length, zero otherwise.
    function automatic void push_model(input logic [DW-1:0] v, input logic [15:0] sz);
        int          eff;
        int          nb;
        int          pos;
        logic [31:0] d;
        eff = (sz > 16) ? 16 : int'(sz);
        nb  = (eff + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            d = '0;
            for (int b = 0; b < 4; b++) begin
                pos = i * 4 + b;
                if (pos < eff) d[b*8 +: 8] = v[pos*8 +: 8];
            end
            sb.push_back({d, (i == nb - 1)});
        end
    endfunction

    // Output monitor / scoreboard consumer, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("first_rdy_eq_deq_rdy", first__RDY, deq__RDY);
            chk("last_rdy_eq_deq_rdy", last__RDY, deq__RDY);
            if (deq__RDY && deq__ENA) begin
                beat_cnt++;
                beat_cycles.push_back(cyc);
                last_hist = {last_hist[6:0], last};
                if (last) last_data = first;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %08h last=%0b, no beat expected", first, last);
                end else begin
                    mon_e = sb.pop_front();
                    chk("beat_data", first, mon_e.d);
                    chk("beat_last", last, mon_e.l);
                end
            end
        end
    end

    // Called on the posedge+1 phase; returns on the posedge+1 phase after the enq fired.
    task automatic send(input logic [DW-1:0] v, input logic [15:0] sz, output int waited);
        enq_v    = v;
        enq_size = sz;
        enq__ENA = 1'b1;
        waited   = 0;
        @(negedge CLK);
        while (!enq__RDY && waited < 40) begin
            waited++;
            @(negedge CLK);
        end
        if (!enq__RDY) begin
            tests++;
            fails++;
            $display("FAIL enq_timeout: enq__RDY stayed 0, required 1 within 40 cycles");
        end else begin
            push_model(v, sz);
        end
        @(posedge CLK);
        #1;
        enq__ENA = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || deq__RDY) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0 || deq__RDY) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d beats still expected, deq__RDY=%0b", sb.size(), deq__RDY);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   w;

        tbl[0] = '{PAT, 16'd16, 4, 32'h0F0E0D0C};
        tbl[1] = '{PAT, 16'd6, 2, 32'h00000504};
        tbl[2] = '{PAT, 16'd4, 1, 32'h03020100};
        tbl[3] = '{PAT, 16'd40, 4, 32'h0F0E0D0C};
        tbl[4] = '{128'h11111111_22222222_33333333_44AABBCC, 16'd1, 1, 32'h000000CC};
        tbl[5] = '{PAT, 16'd13, 4, 32'h0000000C};
        tbl[6] = '{{DW{1'b1}}, 16'd7, 2, 32'h00FFFFFF};
        tbl[7] = '{PAT, 16'hFFFF, 4, 32'h0F0E0D0C};

        enq__ENA  = 1'b0;
        enq_v     = '0;
        enq_size  = '0;
        deq__ENA  = 1'b1;
        beat_cnt  = 0;
        last_data = '0;
        last_hist = '0;

        // Reset state, held and after release.
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_deq_rdy", deq__RDY, 1'b0);
        chk("rst_first", first, 32'h0);
        chk("rst_last", last, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        chk("rel_enq_rdy", enq__RDY, 1'b1);
        chk("rel_deq_rdy", deq__RDY, 1'b0);
        chk("rel_first", first, 32'h0);
        @(posedge CLK);
        #1;

        // Table: each message drained with deq held high.
        for (int i = 0; i < 8; i++) begin
            beat_cnt = 0;
            beat_cycles.delete();
            send(tbl[i].v, tbl[i].size, w);
            drain();
            chk($sformatf("vec%0d_nbeats", i), beat_cnt, tbl[i].n_beats);
            chk($sformatf("vec%0d_last_beat", i), last_data, tbl[i].last_beat);
            if (beat_cycles.size() > 0)
                chk($sformatf("vec%0d_no_gap", i), beat_cycles[beat_cycles.size()-1] - beat_cycles[0], tbl[i].n_beats - 1);
        end

        // Zero-length message: accepted at once, produces nothing.
        beat_cnt = 0;
        send(PAT, 16'd0, w);
        chk("zero_accept_wait", w, 0);
        repeat (3) begin
            @(negedge CLK);
            chk("zero_no_beat", deq__RDY, 1'b0);
        end
        @(posedge CLK);
        #1;
        send(PAT, 16'd4, w);
        drain();
        chk("after_zero_nbeats", beat_cnt, 1);
        chk("after_zero_beat", last_data, 32'h03020100);

        // Back-to-back: second enq fires alongside the first message's final deq.
        beat_cnt = 0;
        beat_cycles.delete();
        last_hist = '0;
        send(PAT, 16'd8, w);
        send(128'hA5A5A5A5_5A5A5A5A_CAFEF00D_DEADBEEF, 16'd8, w);
        drain();
        chk("b2b_nbeats", beat_cnt, 4);
        if (beat_cycles.size() == 4)
            chk("b2b_no_gap", beat_cycles[3] - beat_cycles[0], 3);
        chk("b2b_last_pattern", last_hist[3:0], 4'b0101);

        // Backpressure mid-message, then reset while beat 2 is presented.
        deq__ENA = 1'b0;
        send(PAT, 16'd16, w);
        deq__ENA = 1'b1;
        @(posedge CLK);
        #1;
        deq__ENA = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            chk("stall_first", first, 32'h07060504);
            chk("stall_last", last, 1'b0);
            chk("stall_enq_rdy", enq__RDY, 1'b0);
            chk("stall_deq_rdy", deq__RDY, 1'b1);
        end
        @(posedge CLK);
        #1;
        deq__ENA = 1'b1;
        @(posedge CLK);
        #1;
        deq__ENA = 1'b0;
        #2;
        chk("pre_rst_beat2", first, 32'h0B0A0908);
        RST = 1'b1;
        #1;
        chk("midrst_deq_rdy", deq__RDY, 1'b0);
        chk("midrst_first", first, 32'h0);
        chk("midrst_last", last, 1'b0);
        chk("midrst_first_rdy", first__RDY, 1'b0);
        chk("midrst_last_rdy", last__RDY, 1'b0);
        sb.delete();
        @(posedge CLK);
        #2;
        RST = 1'b0;
        deq__ENA = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            chk("postrst_deq_rdy", deq__RDY, 1'b0);
            chk("postrst_enq_rdy", enq__RDY, 1'b1);
        end
        @(posedge CLK);
        #1;
        beat_cnt = 0;
        send(PAT, 16'd6, w);
        drain();
        chk("postrst_nbeats", beat_cnt, 2);
        chk("postrst_last_beat", last_data, 32'h00000504);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
